uart_tx_serializer: RTL and testbench

//  Downstream consumer of the TX FIFO. Pops one frame per transfer and serializes it

---
 rtl/uart_tx_serializer_if.sv | 12 +
 rtl/uart_tx_serializer.sv | 154 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Pop handshake between the TX FIFO and the UART serializer.
// The serializer is the master: it issues pops and consumes the read data.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_tx_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (input fifo_tx_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_tx_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops frames from the TX FIFO and shifts them out as
// start bit, LSB-first data, optional parity and stop bit(s).
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk_uart_tx,
  input  logic                        rst_n,
  uart_tx_serializer_if.master        fifo,
  output logic                        tx_serial,
  output logic                        tx_busy,
  output logic                        frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  state_t                state_r, state_s;
  logic [BAUD_W-1:0]     baud_r, baud_s;
  logic [BIT_W-1:0]      bit_idx_r, bit_idx_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic                  parity_r, parity_s;
  logic                  baud_end_s;
  logic                  tx_serial_s, frame_done_s;
  logic                  tx_serial_r, fifo_rd_en_r, tx_busy_r, frame_done_r;

  // Next-state, counter and datapath update; outputs are derived from the
  // next register values so the registered outputs line up with the state.
  always_comb begin
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    parity_s     = parity_r;
    baud_end_s   = (baud_r == BAUD_LAST);
    baud_s       = baud_end_s ? '0 : baud_r + BAUD_W'(1);
    tx_serial_s  = 1'b1;
    frame_done_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        baud_s = '0;
        if (!fifo.fifo_tx_empty) state_s = ST_POP;
        else                     state_s = ST_IDLE;
      end
      ST_POP: begin
        baud_s  = '0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        baud_s   = '0;
        shift_s  = fifo.fifo_data;
        parity_s = (^fifo.fifo_data) ^ PAR_ODD;
        state_s  = ST_START;
      end
      ST_START: begin
        if (baud_end_s) state_s = ST_DATA;
        else            state_s = ST_START;
      end
      ST_DATA: begin
        if (baud_end_s) begin
          shift_s = shift_r >> 1;
          if (bit_idx_r == DATA_LAST) begin
            bit_idx_s = '0;
            state_s   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + BIT_W'(1);
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (baud_end_s) state_s = ST_STOP;
        else            state_s = ST_PARITY;
      end
      ST_STOP: begin
        // bit_idx_r doubles as the stop-bit counter
        if (baud_end_s) begin
          if (bit_idx_r == STOP_LAST) begin
            bit_idx_s = '0;
            state_s   = fifo.fifo_tx_empty ? ST_IDLE : ST_POP;
          end else begin
            bit_idx_s = bit_idx_r + BIT_W'(1);
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        baud_s    = '0;
        bit_idx_s = '0;
      end
    endcase

    case (state_s)
      ST_START:  tx_serial_s = 1'b0;
      ST_DATA:   tx_serial_s = shift_s[0];
      ST_PARITY: tx_serial_s = parity_s;
      default:   tx_serial_s = 1'b1;
    endcase

    frame_done_s = (state_s == ST_STOP) && (baud_s == BAUD_LAST) &&
                   (bit_idx_s == STOP_LAST);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk_uart_tx or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      baud_r       <= '0;
      bit_idx_r    <= '0;
      shift_r      <= '0;
      parity_r     <= 1'b0;
      tx_serial_r  <= 1'b1;
      fifo_rd_en_r <= 1'b0;
      tx_busy_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      baud_r       <= baud_s;
      bit_idx_r    <= bit_idx_s;
      shift_r      <= shift_s;
      parity_r     <= parity_s;
      tx_serial_r  <= tx_serial_s;
      fifo_rd_en_r <= (state_s == ST_POP);
      tx_busy_r    <= (state_s != ST_IDLE);
      frame_done_r <= frame_done_s;
    end
  end

  assign fifo.fifo_rd_en = fifo_rd_en_r;
  assign tx_serial       = tx_serial_r;
  assign tx_busy         = tx_busy_r;
  assign frame_done      = frame_done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations fed by small FIFO models,
// line waveform compared cycle by cycle against an expected frame bit pattern.
module tb_uart_tx_serializer;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  uart_tx_serializer_if #(.DATA_WIDTH(8)) if_a ();
  uart_tx_serializer_if #(.DATA_WIDTH(8)) if_b ();
  uart_tx_serializer_if #(.DATA_WIDTH(8)) if_c ();

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;

  // a: 8N1 CPB=16 | b: 8E2 CPB=16 | c: 8O1 CPB=5
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk_uart_tx(clk), .rst_n(rst_n), .fifo(if_a.master), .tx_serial(tx_a), .tx_busy(busy_a), .frame_done(done_a));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    dut_b (.clk_uart_tx(clk), .rst_n(rst_n), .fifo(if_b.master), .tx_serial(tx_b), .tx_busy(busy_b), .frame_done(done_b));
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut_c (.clk_uart_tx(clk), .rst_n(rst_n), .fifo(if_c.master), .tx_serial(tx_c), .tx_busy(busy_c), .frame_done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: memory and write pointer owned by the stimulus, read side by the pop process
  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];
  logic [7:0] mem_c [64];
  logic [5:0] wr_a = 6'd0, wr_b = 6'd0, wr_c = 6'd0;
  logic [5:0] rp_a = 6'd0, rp_b = 6'd0, rp_c = 6'd0;
  int rdcnt_a = 0, rdcnt_b = 0, rdcnt_c = 0;
  int viol = 0;

  assign if_a.fifo_tx_empty = (wr_a == rp_a);
  assign if_b.fifo_tx_empty = (wr_b == rp_b);
  assign if_c.fifo_tx_empty = (wr_c == rp_c);

  always @(posedge clk) begin
    if (if_a.fifo_rd_en) begin
      if_a.fifo_data <= mem_a[rp_a];
      rp_a           <= rp_a + 6'd1;
      rdcnt_a        <= rdcnt_a + 1;
    end
    if (if_b.fifo_rd_en) begin
      if_b.fifo_data <= mem_b[rp_b];
      rp_b           <= rp_b + 6'd1;
      rdcnt_b        <= rdcnt_b + 1;
    end
    if (if_c.fifo_rd_en) begin
      if_c.fifo_data <= mem_c[rp_c];
      rp_c           <= rp_c + 6'd1;
      rdcnt_c        <= rdcnt_c + 1;
    end
    if ((if_a.fifo_rd_en && if_a.fifo_tx_empty) || (if_b.fifo_rd_en && if_b.fifo_tx_empty) ||
        (if_c.fifo_rd_en && if_c.fifo_tx_empty))
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // {fifo_rd_en, tx_serial, tx_busy, frame_done}
  function automatic logic [3:0] obs(input int d);
    case (d)
      0:       return {if_a.fifo_rd_en, tx_a, busy_a, done_a};
      1:       return {if_b.fifo_rd_en, tx_b, busy_b, done_b};
      default: return {if_c.fifo_rd_en, tx_c, busy_c, done_c};
    endcase
  endfunction

  task automatic push(input int d, input logic [7:0] v);
    case (d)
      0:       begin mem_a[wr_a] = v; wr_a = wr_a + 6'd1; end
      1:       begin mem_b[wr_b] = v; wr_b = wr_b + 6'd1; end
      default: begin mem_c[wr_c] = v; wr_c = wr_c + 6'd1; end
    endcase
  endtask

  // Line level for bit slot idx of a frame: start, data LSB first, parity, stops
  function automatic logic exp_bit(input logic [7:0] b, input int idx, input int pen, input int podd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && pen != 0) return 1'(($countones(b) % 2) ^ podd);
    return 1'b1;
  endfunction

  task automatic pop_check(input int d);
    @(negedge clk); chk($sformatf("pop_d%0d", d), obs(d), 4'b1110);
    @(negedge clk); chk($sformatf("wait_d%0d", d), obs(d), 4'b0110);
  endtask

  task automatic frame_check(input int d, input logic [7:0] b, input int pen, input int podd,
                             input int nstop, input int cpb);
    int len;
    len = (1 + 8 + pen + nstop) * cpb;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk($sformatf("frame_d%0d_%02h_c%0d", d, b, i), obs(d),
          {1'b0, exp_bit(b, i / cpb, pen, podd), 1'b1, (i == len - 1)});
    end
  endtask

  task automatic idle_check(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); chk($sformatf("idle_d%0d_c%0d", d, i), obs(d), 4'b0100);
    end
  endtask

  initial begin
    logic [7:0] rb [4];
    logic [7:0] x;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 5);

    // reset asserted mid-idle
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst_a", obs(0), 4'b0100);
    chk("rst_b", obs(1), 4'b0100);
    chk("rst_c", obs(2), 4'b0100);
    @(negedge clk); rst_n = 1'b1;
    idle_check(0, 2);

    // single 0xA5 on 8N1
    push(0, 8'hA5);
    pop_check(0);
    frame_check(0, 8'hA5, 0, 0, 1, 16);
    idle_check(0, 4);
    chk("rdcnt_a5", rdcnt_a, 1);

    // back-to-back 0x00, 0xFF
    push(0, 8'h00); push(0, 8'hFF);
    pop_check(0); frame_check(0, 8'h00, 0, 0, 1, 16);
    pop_check(0); frame_check(0, 8'hFF, 0, 0, 1, 16);
    idle_check(0, 3);
    chk("rdcnt_b2b", rdcnt_a, 3);

    // random back-to-back burst
    for (int i = 0; i < 4; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      push(0, rb[i]);
    end
    for (int i = 0; i < 4; i++) begin
      pop_check(0); frame_check(0, rb[i], 0, 0, 1, 16);
    end
    idle_check(0, 2);
    chk("rdcnt_rand", rdcnt_a, 7);

    // parity: even on b (0x07 -> 1, 0x00 -> 0), odd on c (0x07 -> 0)
    push(1, 8'h07); push(1, 8'h00);
    pop_check(1); frame_check(1, 8'h07, 1, 0, 2, 16);
    pop_check(1); frame_check(1, 8'h00, 1, 0, 2, 16);
    idle_check(1, 2);
    x = 8'($urandom_range(0, 255));
    push(2, 8'h07); push(2, x);
    pop_check(2); frame_check(2, 8'h07, 1, 1, 1, 5);
    pop_check(2); frame_check(2, x, 1, 1, 1, 5);
    idle_check(2, 2);
    chk("rdcnt_c", rdcnt_c, 2);

    // long empty on the two-stop-bit config, then one random byte
    idle_check(1, 1000);
    chk("rdcnt_b_idle", rdcnt_b, 2);
    x = 8'($urandom_range(0, 255));
    push(1, x);
    pop_check(1); frame_check(1, x, 1, 0, 2, 16);
    idle_check(1, 2);

    // reset during data bit 3 of 0x5A: frame abandoned and not resent
    push(0, 8'h5A);
    pop_check(0);
    repeat (16 + 3 * 16 + 8) @(negedge clk);
    chk("pre_rst_busy", obs(0), 4'b0110);
    rst_n = 1'b0; #1;
    chk("abort_rst", obs(0), 4'b0100);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    idle_check(0, 200);
    chk("rdcnt_abort", rdcnt_a, 8);
    push(0, 8'h3C);
    pop_check(0); frame_check(0, 8'h3C, 0, 0, 1, 16);
    idle_check(0, 2);
    chk("rd_while_empty", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
